// File: rtl/ni_output_arbiter.sv
// ---------------------------------------------------------------------------
// ni_output_arbiter
//   Shares the PE's single router injection port between the activation,
//   partial-sum and read-response sources plus the end-of-layer completion
//   message. Round-robin arbitration among data sources, credit tracking of
//   the downstream local-port buffer, registered flit output.
//
// Ports
//   clk_i                 system clock
//   rst_i                 synchronous active-high reset
//   layer_start_i         pulse: new layer, leave DONE
//   act_valid_i/addr/data activation send request      -> act_ready_o
//   psum_valid_i/addr/data partial-sum send request    -> psum_ready_o
//   rd_valid_i/addr/data  read-response request        -> rd_ready_o
//   fin_comp_i            pulse: PE finished the layer
//   downstream_credit_i   one credit returned per asserted cycle
//   out_data_valid_o      1-cycle flit valid pulse to the router
//   out_data_o            flit {type[1:0], addr, data}
//   router_rdy_o          credit count non-zero
//   layer_sent_o          completion flit issued (DONE state)
//   credit_err_o          sticky: credit returned while counter full
// ---------------------------------------------------------------------------
module ni_output_arbiter #(
   parameter  int ADDR_W       = 6,
   parameter  int DATA_W       = 16,
   parameter  int CREDIT_DEPTH = 4,
   localparam int FLIT_W       = 2 + ADDR_W + DATA_W,
   localparam int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              layer_start_i,
   input  logic              act_valid_i,
   input  logic [ADDR_W-1:0] act_addr_i,
   input  logic [DATA_W-1:0] act_data_i,
   output logic              act_ready_o,
   input  logic              psum_valid_i,
   input  logic [ADDR_W-1:0] psum_addr_i,
   input  logic [DATA_W-1:0] psum_data_i,
   output logic              psum_ready_o,
   input  logic              rd_valid_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              rd_ready_o,
   input  logic              fin_comp_i,
   input  logic              downstream_credit_i,
   output logic              out_data_valid_o,
   output logic [FLIT_W-1:0] out_data_o,
   output logic              router_rdy_o,
   output logic              layer_sent_o,
   output logic              credit_err_o
);

   typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} state_e;

   localparam logic [1:0] SRC_ACT  = 2'd0;
   localparam logic [1:0] SRC_PSUM = 2'd1;
   localparam logic [1:0] SRC_RD   = 2'd2;
   localparam logic [CNT_W-1:0] CREDIT_FULL = CNT_W'(CREDIT_DEPTH);

   state_e              state_q, state_d;
   logic [1:0]          rr_q, rr_d;
   logic                fin_pend_q, fin_pend_d;
   logic [CNT_W-1:0]    credit_q, credit_d;
   logic                credit_err_q, credit_err_d;
   logic                out_valid_q, out_valid_d;
   logic [FLIT_W-1:0]   out_data_q, out_data_d;

   logic [2:0]          pick_s;
   logic                can_send_s;
   logic                data_gnt_s;
   logic                fin_gnt_s;

   // Returns {hit, index}: first requesting source at or after ptr, wrapping rd -> act.
   function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] req);
      logic [1:0] idx;
      logic       hit;
      logic [1:0] sel;
      idx = (ptr == 2'd3) ? 2'd0 : ptr;
      hit = 1'b0;
      sel = 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (!hit && req[idx]) begin
            hit = 1'b1;
            sel = idx;
         end
         idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
      return {hit, sel};
   endfunction

   assign pick_s     = rr_pick(rr_q, {rd_valid_i, psum_valid_i, act_valid_i});
   // Reset gates grants so no ready is offered while rst_i is high.
   assign can_send_s = !rst_i && (state_q == ST_RUN) && (credit_q != {CNT_W{1'b0}});
   assign data_gnt_s = can_send_s && pick_s[2];
   // Completion only goes out when no data source is asking.
   assign fin_gnt_s  = can_send_s && !pick_s[2] && fin_pend_q;

   assign act_ready_o      = data_gnt_s && (pick_s[1:0] == SRC_ACT);
   assign psum_ready_o     = data_gnt_s && (pick_s[1:0] == SRC_PSUM);
   assign rd_ready_o       = data_gnt_s && (pick_s[1:0] == SRC_RD);
   assign out_data_valid_o = out_valid_q;
   assign out_data_o       = out_data_q;
   assign router_rdy_o     = (credit_q != {CNT_W{1'b0}});
   assign layer_sent_o     = (state_q == ST_DONE);
   assign credit_err_o     = credit_err_q;

   // Next-state: arbitration pointer, flit formatting, credits, completion FSM.
   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      fin_pend_d   = fin_pend_q;
      credit_d     = credit_q;
      credit_err_d = credit_err_q;
      out_valid_d  = data_gnt_s || fin_gnt_s;
      out_data_d   = out_data_q;

      if (data_gnt_s) begin
         case (pick_s[1:0])
            SRC_ACT: begin
               out_data_d = {2'b00, act_addr_i, act_data_i};
               rr_d       = SRC_PSUM;
            end
            SRC_PSUM: begin
               out_data_d = {2'b01, psum_addr_i, psum_data_i};
               rr_d       = SRC_RD;
            end
            SRC_RD: begin
               out_data_d = {2'b10, rd_addr_i, rd_data_i};
               rr_d       = SRC_ACT;
            end
            default: begin
               out_data_d = out_data_q;
               rr_d       = rr_q;
            end
         endcase
      end else if (fin_gnt_s) begin
         out_data_d = {2'b11, {ADDR_W{1'b1}}, {DATA_W{1'b0}}};
      end else begin
         out_data_d = out_data_q;
      end

      case (state_q)
         ST_RUN: begin
            if (fin_gnt_s) begin
               fin_pend_d = 1'b0;
               state_d    = ST_DONE;
            end else if (fin_comp_i) begin
               fin_pend_d = 1'b1;
            end else begin
               fin_pend_d = fin_pend_q;
            end
         end
         ST_DONE: begin
            if (layer_start_i) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // A grant and a returned credit in the same cycle cancel out.
      case ({(data_gnt_s || fin_gnt_s), downstream_credit_i})
         2'b10: begin
            credit_d = credit_q - CNT_W'(1);
         end
         2'b01: begin
            if (credit_q == CREDIT_FULL) begin
               credit_err_d = 1'b1;
            end else begin
               credit_d = credit_q + CNT_W'(1);
            end
         end
         default: begin
            credit_d = credit_q;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_RUN;
         rr_q         <= SRC_ACT;
         fin_pend_q   <= 1'b0;
         credit_q     <= CREDIT_FULL;
         credit_err_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= {FLIT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         fin_pend_q   <= fin_pend_d;
         credit_q     <= credit_d;
         credit_err_q <= credit_err_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
      end
   end

endmodule

// File: tb/tb_ni_output_arbiter.sv
module tb_ni_output_arbiter;

   logic        clk;
   logic        rst;
   logic        layer_start;
   logic        act_valid, psum_valid, rd_valid;
   logic [5:0]  act_addr, psum_addr, rd_addr;
   logic [15:0] act_data, psum_data, rd_data;
   logic        act_ready, psum_ready, rd_ready;
   logic        fin_comp;
   logic        dcredit;
   logic        out_valid;
   logic [23:0] out_data;
   logic        router_rdy;
   logic        layer_sent;
   logic        credit_err;

   int checks = 0;
   int errors = 0;

   ni_output_arbiter #(.ADDR_W(6), .DATA_W(16), .CREDIT_DEPTH(4)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .layer_start_i       (layer_start),
      .act_valid_i         (act_valid),
      .act_addr_i          (act_addr),
      .act_data_i          (act_data),
      .act_ready_o         (act_ready),
      .psum_valid_i        (psum_valid),
      .psum_addr_i         (psum_addr),
      .psum_data_i         (psum_data),
      .psum_ready_o        (psum_ready),
      .rd_valid_i          (rd_valid),
      .rd_addr_i           (rd_addr),
      .rd_data_i           (rd_data),
      .rd_ready_o          (rd_ready),
      .fin_comp_i          (fin_comp),
      .downstream_credit_i (dcredit),
      .out_data_valid_o    (out_valid),
      .out_data_o          (out_data),
      .router_rdy_o        (router_rdy),
      .layer_sent_o        (layer_sent),
      .credit_err_o        (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      layer_start = 1'b0;
      act_valid = 1'b0; psum_valid = 1'b0; rd_valid = 1'b0;
      act_addr = 6'h00; psum_addr = 6'h00; rd_addr = 6'h00;
      act_data = 16'h0000; psum_data = 16'h0000; rd_data = 16'h0000;
      fin_comp = 1'b0;
      dcredit = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      act_valid = 1'b1; act_addr = 6'h2A; act_data = 16'h5A5A;
      cyc();
      @(negedge clk);
      checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL rst_act_ready got %b exp 0", act_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== 24'h000000) begin errors++; $display("FAIL rst_out_data got %h exp 000000", out_data); end
      checks++; if (router_rdy !== 1'b1) begin errors++; $display("FAIL rst_router_rdy got %b exp 1", router_rdy); end
      checks++; if (layer_sent !== 1'b0) begin errors++; $display("FAIL rst_layer_sent got %b exp 0", layer_sent); end
      checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL rst_credit_err got %b exp 0", credit_err); end
      cyc();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL post_rst_grant got %b exp 1", act_ready); end
      cyc();
      act_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 24'h2A5A5A) begin
         errors++; $display("FAIL post_rst_flit got %b/%h exp 1/2A5A5A", out_valid, out_data); end
      cyc();
   endtask

   task automatic test_credit_stall();
      logic [15:0] val;
      logic [15:0] prev;
      logic        exp_rdy;
      logic        exp_v;
      int          idx;
      apply_reset();
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         act_valid = 1'b1; act_addr = 6'h05;
         val = 16'h0100 + 16'(idx);
         act_data = val;
         @(negedge clk);
         exp_rdy = (c < 4);
         exp_v   = (c >= 1 && c <= 4);
         prev    = 16'h0100 + 16'(c - 1);
         checks++; if (act_ready !== exp_rdy) begin errors++; $display("FAIL stall_ready c%0d got %b exp %b", c, act_ready, exp_rdy); end
         checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stall_valid c%0d got %b exp %b", c, out_valid, exp_v); end
         if (c >= 1) begin
            checks++; if (out_data !== {2'b00, 6'h05, (c <= 4) ? prev : 16'h0103}) begin
               errors++; $display("FAIL stall_flit c%0d got %h", c, out_data); end
         end
         if (c == 4) begin
            checks++; if (router_rdy !== 1'b0) begin errors++; $display("FAIL stall_router_rdy got %b exp 0", router_rdy); end
         end
         if (exp_rdy) idx++;
         cyc();
      end
      act_data = 16'h0104;
      dcredit = 1'b1;
      @(negedge clk);
      checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL credit_ret_ready got %b exp 0", act_ready); end
      cyc();
      dcredit = 1'b0;
      @(negedge clk);
      checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL fifth_grant got %b exp 1", act_ready); end
      cyc();
      act_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 24'h050104) begin
         errors++; $display("FAIL fifth_flit got %b/%h exp 1/050104", out_valid, out_data); end
      cyc();
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_r [5];
      logic [1:0] exp_t [5];
      exp_r = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
      exp_t = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
      apply_reset();
      act_valid = 1'b1;  act_addr = 6'h01;  act_data = 16'hAAAA;
      psum_valid = 1'b1; psum_addr = 6'h02; psum_data = 16'hBBBB;
      rd_valid = 1'b1;   rd_addr = 6'h03;   rd_data = 16'hCCCC;
      dcredit = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if ({rd_ready, psum_ready, act_ready} !== exp_r[c]) begin
            errors++; $display("FAIL rr_grant c%0d got %b exp %b", c, {rd_ready, psum_ready, act_ready}, exp_r[c]); end
         if (c >= 1) begin
            checks++; if (out_valid !== 1'b1 || out_data[23:22] !== exp_t[c-1]) begin
               errors++; $display("FAIL rr_type c%0d got %b/%b exp 1/%b", c, out_valid, out_data[23:22], exp_t[c-1]); end
         end
         cyc();
      end
      idle_inputs();
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 24'h42BBBB) begin
         errors++; $display("FAIL rr_last_flit got %b/%h exp 1/42BBBB", out_valid, out_data); end
      checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL rr_credit_err got %b exp 0", credit_err); end
      cyc();
   endtask

   task automatic test_completion();
      apply_reset();
      psum_valid = 1'b1; psum_addr = 6'h07; psum_data = 16'h1000; fin_comp = 1'b1;
      @(negedge clk);
      checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL fin_psum0 got %b exp 1", psum_ready); end
      cyc();
      fin_comp = 1'b0; psum_data = 16'h1001;
      @(negedge clk);
      checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL fin_psum1 got %b exp 1", psum_ready); end
      checks++; if (out_data !== 24'h471000) begin errors++; $display("FAIL fin_psum_flit0 got %h exp 471000", out_data); end
      cyc();
      psum_data = 16'h1002;
      @(negedge clk);
      checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL fin_psum2 got %b exp 1", psum_ready); end
      cyc();
      psum_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 24'h471002) begin
         errors++; $display("FAIL fin_psum_flit2 got %b/%h exp 1/471002", out_valid, out_data); end
      checks++; if (layer_sent !== 1'b0) begin errors++; $display("FAIL fin_early_sent got %b exp 0", layer_sent); end
      cyc();
      dcredit = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 24'hFF0000) begin
         errors++; $display("FAIL fin_flit got %b/%h exp 1/FF0000", out_valid, out_data); end
      checks++; if (layer_sent !== 1'b1) begin errors++; $display("FAIL fin_layer_sent got %b exp 1", layer_sent); end
      for (int k = 0; k < 3; k++) cyc();
      cyc();
      dcredit = 1'b0;
      act_valid = 1'b1; act_addr = 6'h09; act_data = 16'h7777; fin_comp = 1'b1;
      @(negedge clk);
      checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL done_act_ready got %b exp 0", act_ready); end
      checks++; if (layer_sent !== 1'b1 || credit_err !== 1'b0) begin
         errors++; $display("FAIL done_state got %b/%b exp 1/0", layer_sent, credit_err); end
      cyc();
      fin_comp = 1'b0; layer_start = 1'b1;
      @(negedge clk);
      checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL done_start_ready got %b exp 0", act_ready); end
      cyc();
      layer_start = 1'b0;
      @(negedge clk);
      checks++; if (act_ready !== 1'b1 || layer_sent !== 1'b0) begin
         errors++; $display("FAIL restart got %b/%b exp 1/0", act_ready, layer_sent); end
      cyc();
      act_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 24'h097777) begin
         errors++; $display("FAIL restart_flit got %b/%h exp 1/097777", out_valid, out_data); end
      for (int k = 0; k < 2; k++) begin
         cyc();
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL done_fin_ignored k%0d got %b exp 0", k, out_valid); end
      end
      cyc();
   endtask

   task automatic test_credit_cancel();
      logic exp_rdy;
      apply_reset();
      act_valid = 1'b1; act_addr = 6'h11; act_data = 16'h2222;
      cyc();
      cyc();
      dcredit = 1'b1;
      @(negedge clk);
      checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL cancel_grant got %b exp 1", act_ready); end
      cyc();
      dcredit = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         exp_rdy = (k < 2);
         checks++; if (act_ready !== exp_rdy) begin errors++; $display("FAIL cancel_drain k%0d got %b exp %b", k, act_ready, exp_rdy); end
         cyc();
      end
      act_valid = 1'b0;
   endtask

   task automatic test_credit_overflow();
      logic exp_rdy;
      apply_reset();
      dcredit = 1'b1;
      @(negedge clk);
      checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", credit_err); end
      cyc();
      dcredit = 1'b0;
      @(negedge clk);
      checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", credit_err); end
      cyc();
      act_valid = 1'b1; act_addr = 6'h12; act_data = 16'h3333;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         exp_rdy = (k < 4);
         checks++; if (act_ready !== exp_rdy) begin errors++; $display("FAIL ovf_drain k%0d got %b exp %b", k, act_ready, exp_rdy); end
         cyc();
      end
      act_valid = 1'b0;
      @(negedge clk);
      checks++; if (credit_err !== 1'b1 || router_rdy !== 1'b0) begin
         errors++; $display("FAIL ovf_sticky got %b/%b exp 1/0", credit_err, router_rdy); end
      apply_reset();
      @(negedge clk);
      checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", credit_err); end
      cyc();
   endtask

   task automatic test_reset_mid_burst();
      logic exp_rdy;
      apply_reset();
      act_valid = 1'b1; act_addr = 6'h13; act_data = 16'h4444; fin_comp = 1'b1;
      cyc();
      fin_comp = 1'b0;
      cyc();
      cyc();
      act_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", act_ready); end
      cyc();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || out_data !== 24'h000000) begin
         errors++; $display("FAIL mid_rst_out got %b/%h exp 0/000000", out_valid, out_data); end
      checks++; if (router_rdy !== 1'b1 || layer_sent !== 1'b0) begin
         errors++; $display("FAIL mid_rst_state got %b/%b exp 1/0", router_rdy, layer_sent); end
      for (int k = 0; k < 3; k++) begin
         cyc();
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_fin k%0d got %b exp 0", k, out_valid); end
      end
      cyc();
      act_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         exp_rdy = (k < 4);
         checks++; if (act_ready !== exp_rdy) begin errors++; $display("FAIL mid_rst_credit k%0d got %b exp %b", k, act_ready, exp_rdy); end
         cyc();
      end
      act_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_credit_stall();
      test_round_robin();
      test_completion();
      test_credit_cancel();
      test_credit_overflow();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
